// File: rtl/seq_div_array.sv
// Iterative radix-2 restoring divider: WIDTH-cycle quotient/remainder with valid/ready handshakes.
// Optional `DIV_SIGNED_EN adds an is_signed input for two's-complement division.
module seq_div_array #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
`ifdef DIV_SIGNED_EN
   input  logic             is_signed,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   r_sh;
   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] r_nx;
   logic [WIDTH-1:0] q_nx;

   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

`ifdef DIV_SIGNED_EN
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic             sgn_a, sgn_b;
   logic             ovf;

   function automatic logic [WIDTH-1:0] neg_if(input logic c, input logic [WIDTH-1:0] v);
      return c ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
   endfunction
`endif

   // The partial remainder always stays below the divisor, so its extra
   // (WIDTH+1)th bit only ever exists in the shifted trial value.
   always_comb begin
      r_sh  = {r_q, q_q[WIDTH-1]};
      trial = r_sh - {1'b0, d_q};
      fits  = ~trial[WIDTH];
      r_nx  = fits ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
      q_nx  = {q_q[WIDTH-2:0], fits};
   end

`ifdef DIV_SIGNED_EN
   always_comb begin
      sgn_a   = is_signed & dividend_in[WIDTH-1];
      sgn_b   = is_signed & divisor_in[WIDTH-1];
      dvd_mag = neg_if(sgn_a, dividend_in);
      dvs_mag = neg_if(sgn_b, divisor_in);
      ovf     = is_signed && (dividend_in == {1'b1, {(WIDTH-1){1'b0}}})
                          && (divisor_in == {WIDTH{1'b1}});
   end
`else
   always_comb begin
      dvd_mag = dividend_in;
      dvs_mag = divisor_in;
   end
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      q_d       = q_q;
      r_d       = r_q;
      d_d       = d_q;
      dbz_d     = dbz_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_d   = neg_q_q;
      neg_r_d   = neg_r_q;
`endif
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (divisor_in == '0) begin
                  state_d = DONE;
                  q_d     = {WIDTH{1'b1}};
                  r_d     = dividend_in;
                  dbz_d   = 1'b1;
`ifdef DIV_SIGNED_EN
               end else if (ovf) begin
                  state_d = DONE;
                  q_d     = dividend_in;
                  r_d     = '0;
                  dbz_d   = 1'b0;
`endif
               end else begin
                  state_d = CALC;
                  q_d     = dvd_mag;
                  d_d     = dvs_mag;
                  r_d     = '0;
                  cnt_d   = CNT_W'(WIDTH);
                  dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                  neg_q_d = sgn_a ^ sgn_b;
                  neg_r_d = sgn_a;
`endif
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            q_d   = q_nx;
            r_d   = r_nx;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
`ifdef DIV_SIGNED_EN
               // Sign fix-up folds into the final iteration so DONE costs no extra cycle.
               q_d = neg_if(neg_q_q, q_nx);
               r_d = neg_if(neg_r_q, r_nx);
`endif
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
               dbz_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

   assign quotient    = q_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_array.sv
// Directed bench for seq_div_array at WIDTH=8; signed cases only when DIV_SIGNED_EN is defined.
module tb_seq_div_array;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend_in;
   logic [7:0] divisor_in;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;
`ifdef DIV_SIGNED_EN
   logic       is_signed;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_div_array #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend_in (dividend_in),
      .divisor_in  (divisor_in),
`ifdef DIV_SIGNED_EN
      .is_signed   (is_signed),
`endif
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands until accepted; afterwards scribble the inputs to prove they are not re-sampled.
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
      int k = 0;
      while (!in_ready && k < 100) begin
         step();
         k++;
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
      end
      in_valid    = 1'b1;
      dividend_in = a;
      divisor_in  = b;
`ifdef DIV_SIGNED_EN
      is_signed   = s;
`else
      if (s) $display("note: signed request ignored in unsigned build");
`endif
      step();
      in_valid    = 1'b0;
      dividend_in = 8'hAA;
      divisor_in  = 8'h00;
   endtask

   // Returns the cycle index (1 = first cycle after accept) at which out_valid is seen.
   task automatic wait_out(output int n);
      n = 1;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      n_checks++; if (quotient !== 8'd0)    begin n_fail++; $display("FAIL rst_quotient: got %0d want 0", quotient); end
      n_checks++; if (remainder !== 8'd0)   begin n_fail++; $display("FAIL rst_remainder: got %0d want 0", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL rst_dbz: got %b want 0", div_by_zero); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int n;
      out_ready = 1'b1;
      issue(8'd100, 8'd7, 1'b0);
      wait_out(n);
      n_checks++; if (n !== 9)              begin n_fail++; $display("FAIL basic_latency: got %0d want 9", n); end
      n_checks++; if (quotient !== 8'd14)   begin n_fail++; $display("FAIL basic_quot: got %0d want 14", quotient); end
      n_checks++; if (remainder !== 8'd2)   begin n_fail++; $display("FAIL basic_rem: got %0d want 2", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
      step();
      n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL basic_ov_clear: got %b want 0", out_valid); end
   endtask

   task automatic test_div_zero();
      int n;
      out_ready = 1'b1;
      issue(8'd55, 8'd0, 1'b0);
      wait_out(n);
      n_checks++; if (n !== 1)              begin n_fail++; $display("FAIL dz_latency: got %0d want 1", n); end
      n_checks++; if (quotient !== 8'hFF)   begin n_fail++; $display("FAIL dz_quot: got %0h want ff", quotient); end
      n_checks++; if (remainder !== 8'd55)  begin n_fail++; $display("FAIL dz_rem: got %0d want 55", remainder); end
      n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
      step();
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dz_flag_clear: got %b want 0", div_by_zero); end
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b1;
      issue(8'd255, 8'd255, 1'b0);
      wait_out(n);
      n_checks++; if (quotient !== 8'd1)  begin n_fail++; $display("FAIL b2b_q1: got %0d want 1", quotient); end
      n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL b2b_r1: got %0d want 0", remainder); end
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL b2b_ready_hs: got %b want 0", in_ready); end
      step();
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL b2b_ready_rise: got %b want 1", in_ready); end
      issue(8'd3, 8'd10, 1'b0);
      wait_out(n);
      n_checks++; if (n !== 9)            begin n_fail++; $display("FAIL b2b_latency2: got %0d want 9", n); end
      n_checks++; if (quotient !== 8'd0)  begin n_fail++; $display("FAIL b2b_q2: got %0d want 0", quotient); end
      n_checks++; if (remainder !== 8'd3) begin n_fail++; $display("FAIL b2b_r2: got %0d want 3", remainder); end
      step();
   endtask

   task automatic test_backpressure();
      int n;
      out_ready = 1'b0;
      issue(8'd200, 8'd3, 1'b0);
      wait_out(n);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL bp_ov[%0d]: got %b want 1", i, out_valid); end
         n_checks++; if (quotient !== 8'd66)  begin n_fail++; $display("FAIL bp_quot[%0d]: got %0d want 66", i, quotient); end
         n_checks++; if (remainder !== 8'd2)  begin n_fail++; $display("FAIL bp_rem[%0d]: got %0d want 2", i, remainder); end
         n_checks++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
         step();
      end
      out_ready = 1'b1;
      step();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_ov_clear: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_ready_rise: got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int n;
      out_ready = 1'b1;
      issue(8'd77, 8'd5, 1'b0);
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ov: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_ready: got %b want 1", in_ready); end
      n_checks++; if (quotient !== 8'd0)  begin n_fail++; $display("FAIL mid_quot: got %0d want 0", quotient); end
      n_checks++; if (remainder !== 8'd0) begin n_fail++; $display("FAIL mid_rem: got %0d want 0", remainder); end
      issue(8'd77, 8'd5, 1'b0);
      wait_out(n);
      n_checks++; if (n !== 9)             begin n_fail++; $display("FAIL mid_latency: got %0d want 9", n); end
      n_checks++; if (quotient !== 8'd15)  begin n_fail++; $display("FAIL mid_q2: got %0d want 15", quotient); end
      n_checks++; if (remainder !== 8'd2)  begin n_fail++; $display("FAIL mid_r2: got %0d want 2", remainder); end
      step();
   endtask

   task automatic test_boundaries();
      logic [7:0] va [4] = '{8'd5, 8'd123, 8'd0,  8'd254};
      logic [7:0] vb [4] = '{8'd9, 8'd1,   8'd7,  8'd16};
      logic [7:0] eq [4] = '{8'd0, 8'd123, 8'd0,  8'd15};
      logic [7:0] er [4] = '{8'd5, 8'd0,   8'd0,  8'd14};
      int n;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(va[i], vb[i], 1'b0);
         wait_out(n);
         n_checks++; if (quotient !== eq[i])  begin n_fail++; $display("FAIL bnd_quot[%0d]: got %0d want %0d", i, quotient, eq[i]); end
         n_checks++; if (remainder !== er[i]) begin n_fail++; $display("FAIL bnd_rem[%0d]: got %0d want %0d", i, remainder, er[i]); end
         step();
      end
   endtask

`ifdef DIV_SIGNED_EN
   task automatic test_signed();
      int n;
      out_ready = 1'b1;
      issue(8'hF9, 8'h02, 1'b1);
      wait_out(n);
      n_checks++; if (n !== 9)              begin n_fail++; $display("FAIL sgn_latency: got %0d want 9", n); end
      n_checks++; if (quotient !== 8'hFD)   begin n_fail++; $display("FAIL sgn_quot: got %0h want fd", quotient); end
      n_checks++; if (remainder !== 8'hFF)  begin n_fail++; $display("FAIL sgn_rem: got %0h want ff", remainder); end
      step();
      issue(8'h80, 8'hFF, 1'b1);
      wait_out(n);
      n_checks++; if (n !== 1)              begin n_fail++; $display("FAIL ovf_latency: got %0d want 1", n); end
      n_checks++; if (quotient !== 8'h80)   begin n_fail++; $display("FAIL ovf_quot: got %0h want 80", quotient); end
      n_checks++; if (remainder !== 8'h00)  begin n_fail++; $display("FAIL ovf_rem: got %0h want 0", remainder); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b want 0", div_by_zero); end
      step();
   endtask
`endif

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      dividend_in = 8'd0;
      divisor_in  = 8'd0;
`ifdef DIV_SIGNED_EN
      is_signed   = 1'b0;
`endif
      test_reset();
      test_basic();
      test_div_zero();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_boundaries();
`ifdef DIV_SIGNED_EN
      test_signed();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
